// File: rtl/latch_write_ctrl.sv
// Clocked write sequencer for a transparent latch bank: accepts a word over valid/ready,
// then drives setup, enable-pulse and hold phases so the latch captures the word cleanly.
module latch_write_ctrl #(
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] lat_d,
    output logic             lat_en,
    output logic             busy,
    output logic             done,
    output logic [15:0]      wr_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Each phase counter is loaded with (length - 1) and the phase ends when it reaches 0.
    localparam logic [7:0] SETUP_LOAD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYC - 1);
    localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_CYC - 1);

    state_t           state_reg;
    logic [7:0]       phase_cnt_reg;
    logic [WIDTH-1:0] lat_d_reg;
    logic             lat_en_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [15:0]      wr_count_reg;

    logic phase_last;
    assign phase_last = (phase_cnt_reg == 8'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            phase_cnt_reg <= 8'd0;
            lat_d_reg     <= '0;
            lat_en_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            wr_count_reg  <= 16'd0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // lat_d only moves here, a full setup window ahead of any enable.
                    if (in_valid) begin
                        state_reg     <= SETUP;
                        phase_cnt_reg <= SETUP_LOAD;
                        lat_d_reg     <= in_data;
                        busy_reg      <= 1'b1;
                    end
                end
                SETUP: begin
                    if (phase_last) begin
                        state_reg     <= PULSE;
                        phase_cnt_reg <= PULSE_LOAD;
                        lat_en_reg    <= 1'b1;
                    end else begin
                        phase_cnt_reg <= phase_cnt_reg - 8'd1;
                    end
                end
                PULSE: begin
                    if (phase_last) begin
                        state_reg     <= HOLD;
                        phase_cnt_reg <= HOLD_LOAD;
                        lat_en_reg    <= 1'b0;
                    end else begin
                        phase_cnt_reg <= phase_cnt_reg - 8'd1;
                    end
                end
                HOLD: begin
                    if (phase_last) begin
                        state_reg    <= IDLE;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                        wr_count_reg <= wr_count_reg + 16'd1;
                    end else begin
                        phase_cnt_reg <= phase_cnt_reg - 8'd1;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    lat_en_reg <= 1'b0;
                    busy_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = rst_n && (state_reg == IDLE);
    assign lat_d    = lat_d_reg;
    assign lat_en   = lat_en_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign wr_count = wr_count_reg;

endmodule

// File: tb/tb_latch_write_ctrl.sv
// Directed bench for latch_write_ctrl: default-parameter instance plus an S=3/P=1/H=4 instance,
// per-cycle output traces compared against hand-computed bit masks.
module tb_latch_write_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_a, valid_b;
    logic [7:0]  in_data;

    logic        ready_a, lat_en_a, busy_a, done_a;
    logic [7:0]  lat_d_a;
    logic [15:0] wr_count_a;
    logic        ready_b, lat_en_b, busy_b, done_b;
    logic [7:0]  lat_d_b;
    logic [15:0] wr_count_b;

    always #5 clk = ~clk;

    latch_write_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(valid_a), .in_ready(ready_a), .in_data(in_data),
        .lat_d(lat_d_a), .lat_en(lat_en_a), .busy(busy_a), .done(done_a), .wr_count(wr_count_a)
    );

    latch_write_ctrl #(.WIDTH(8), .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(valid_b), .in_ready(ready_b), .in_data(in_data),
        .lat_d(lat_d_b), .lat_en(lat_en_b), .busy(busy_b), .done(done_b), .wr_count(wr_count_b)
    );

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] en_tr, done_tr, rdy_tr, busy_tr, acc_tr;
    logic [7:0]  ld_tr  [32];
    logic [15:0] cnt_tr [32];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Runs n cycles starting just after a rising edge; cycle c drives valid=vmask[c] and
    // data d0 (c < sw) or d1, and records the selected instance's outputs for that cycle.
    task automatic run_seq(input bit sel_b, input int n, input logic [31:0] vmask,
                           input logic [7:0] d0, input logic [7:0] d1, input int sw);
        logic rdy;
        en_tr = '0; done_tr = '0; rdy_tr = '0; busy_tr = '0; acc_tr = '0;
        for (int c = 0; c < n; c++) begin
            in_data = (c < sw) ? d0 : d1;
            if (sel_b) valid_b = vmask[c];
            else       valid_a = vmask[c];
            #1;
            rdy        = sel_b ? ready_b : ready_a;
            rdy_tr[c]  = rdy;
            acc_tr[c]  = vmask[c] & rdy;
            en_tr[c]   = sel_b ? lat_en_b : lat_en_a;
            done_tr[c] = sel_b ? done_b : done_a;
            busy_tr[c] = sel_b ? busy_b : busy_a;
            ld_tr[c]   = sel_b ? lat_d_b : lat_d_a;
            cnt_tr[c]  = sel_b ? wr_count_b : wr_count_a;
            @(posedge clk);
            #1;
        end
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_lat_d",   32'(lat_d_a), 32'h0);
        check("rst_lat_en",  32'(lat_en_a), 32'h0);
        check("rst_busy",    32'(busy_a), 32'h0);
        check("rst_done",    32'(done_a), 32'h0);
        check("rst_count",   32'(wr_count_a), 32'h0);
        check("rst_ready_a", 32'(ready_a), 32'h0);
        check("rst_ready_b", 32'(ready_b), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single write 0xA5 accepted in cycle 0
        run_seq(1'b0, 7, 32'h1, 8'hA5, 8'hA5, 99);
        check("single_lat_en", en_tr, 32'h0C);
        check("single_done",   done_tr, 32'h20);
        check("single_ready",  rdy_tr, 32'h61);
        check("single_busy",   busy_tr, 32'h1E);
        check("single_ld_c0",  32'(ld_tr[0]), 32'h00);
        check("single_ld_c1",  32'(ld_tr[1]), 32'hA5);
        check("single_cnt_c4", 32'(cnt_tr[4]), 32'h0);
        check("single_cnt_c5", 32'(cnt_tr[5]), 32'h1);

        // Back-to-back: valid held cycles 0..5, 0x11 then 0x22 from cycle 5
        run_seq(1'b0, 12, 32'h3F, 8'h11, 8'h22, 5);
        check("b2b_accept",  acc_tr, 32'h21);
        check("b2b_lat_en",  en_tr, 32'h18C);
        check("b2b_done",    done_tr, 32'h420);
        check("b2b_ld_c5",   32'(ld_tr[5]), 32'h11);
        check("b2b_ld_c6",   32'(ld_tr[6]), 32'h22);
        check("b2b_ld_c11",  32'(ld_tr[11]), 32'h22);
        check("b2b_cnt_c9",  32'(cnt_tr[9]), 32'h2);
        check("b2b_cnt_c10", 32'(cnt_tr[10]), 32'h3);

        // S=3, P=1, H=4 instance
        run_seq(1'b1, 11, 32'h1, 8'h3C, 8'h3C, 99);
        check("param_lat_en", en_tr, 32'h10);
        check("param_done",   done_tr, 32'h200);
        check("param_ready",  rdy_tr, 32'h601);
        check("param_busy",   busy_tr, 32'h1FE);
        check("param_ld_c1",  32'(ld_tr[1]), 32'h3C);
        check("param_cnt_c9", 32'(cnt_tr[9]), 32'h1);

        // Accept 0x0F, then offer 0xF0 during PULSE (cycles 2-3)
        run_seq(1'b0, 7, 32'h0D, 8'h0F, 8'hF0, 1);
        check("busydata_accept", acc_tr, 32'h01);
        check("busydata_ld_c3",  32'(ld_tr[3]), 32'h0F);
        check("busydata_ld_c6",  32'(ld_tr[6]), 32'h0F);
        check("busydata_done",   done_tr, 32'h20);
        check("busydata_cnt_c5", 32'(cnt_tr[5]), 32'h4);

        // Reset for one cycle while in PULSE
        run_seq(1'b0, 3, 32'h1, 8'h77, 8'h77, 99);
        check("midrst_in_pulse", 32'(lat_en_a), 32'h1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_lat_en", 32'(lat_en_a), 32'h0);
        check("midrst_busy",   32'(busy_a), 32'h0);
        check("midrst_done",   32'(done_a), 32'h0);
        check("midrst_lat_d",  32'(lat_d_a), 32'h0);
        check("midrst_count",  32'(wr_count_a), 32'h0);
        check("midrst_ready_low", 32'(ready_a), 32'h0);
        rst_n = 1'b1;
        #1;
        check("midrst_ready_high", 32'(ready_a), 32'h1);
        run_seq(1'b0, 6, 32'h0, 8'h00, 8'h00, 99);
        check("midrst_no_done", done_tr, 32'h0);
        check("midrst_no_busy", busy_tr, 32'h0);
        check("midrst_cnt_c5",  32'(cnt_tr[5]), 32'h0);

        // Counter wrap: preload 0xFFFF, then one write
        force dut_a.wr_count_reg = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut_a.wr_count_reg;
        #1;
        check("wrap_preload", 32'(wr_count_a), 32'hFFFF);
        run_seq(1'b0, 7, 32'h1, 8'h5A, 8'h5A, 99);
        check("wrap_cnt_c4", 32'(cnt_tr[4]), 32'hFFFF);
        check("wrap_cnt_c5", 32'(cnt_tr[5]), 32'h0);
        check("wrap_done",   done_tr, 32'h20);
        check("wrap_ld_c1",  32'(ld_tr[1]), 32'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
